// File: rtl/spi_master_ext.sv
// SPI master with per-transfer CPOL/CPHA, bit order and chip-select hold.
// Word timing is driven by one half-period divider shared by LEAD, XFER and TRAIL.
module spi_master_ext #(
  parameter int DATA_W   = 8,
  parameter int HALF_DIV = 5,
  parameter int NUM_SS   = 4,
  parameter int SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              hold_ss,
  input  logic              release_ss,
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic [NUM_SS-1:0] ss_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out
);
  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int EDG_W = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, HOLD} state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div;
  logic [EDG_W-1:0]   ecnt;
  logic [DATA_W-1:0]  tx, rx;
  logic               cpol_q, cpha_q, lsb_q, hold_q;
  logic               accept, tick, last_edge, leading;

  function automatic logic [NUM_SS-1:0] sel_dec(input logic [SS_W-1:0] s);
    sel_dec = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (s == SS_W'(i)) sel_dec[i] = 1'b0;
  endfunction

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign tick      = (div == DIV_W'(HALF_DIV - 1));
  assign last_edge = (ecnt == EDG_W'(2 * DATA_W - 1));
  assign leading   = ~ecnt[0];  // edge number ecnt+1 is odd
  assign busy      = (state == LEAD) || (state == XFER) || (state == TRAIL);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:  if (start) begin accept = 1'b1; state_nxt = LEAD; end
      LEAD:  if (tick) state_nxt = XFER;
      XFER:  if (tick && last_edge) state_nxt = TRAIL;
      TRAIL: if (tick) state_nxt = hold_q ? HOLD : IDLE;
      HOLD: begin
        if (start) begin accept = 1'b1; state_nxt = LEAD; end
        else if (release_ss) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0; ecnt <= '0; tx <= '0; rx <= '0;
      sck <= 1'b0; mosi <= 1'b0; ss_n <= '1; done <= 1'b0; data_out <= '0;
      cpol_q <= 1'b0; cpha_q <= 1'b0; lsb_q <= 1'b0; hold_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) div <= tick ? '0 : div + 1'b1;
      else      div <= '0;

      if (accept) begin
        cpol_q <= cpol; cpha_q <= cpha; lsb_q <= lsb_first; hold_q <= hold_ss;
        sck  <= cpol;
        ecnt <= '0;
        rx   <= '0;
        if (state == IDLE) ss_n <= sel_dec(ss_sel);
        // cpha=0 presents the first bit before any SCK edge
        if (cpha) tx <= data_in;
        else begin
          mosi <= first_bit(data_in, lsb_first);
          tx   <= shift_word(data_in, lsb_first);
        end
      end

      if (state == HOLD && !start && release_ss) ss_n <= '1;

      if (state == XFER && tick) begin
        sck  <= ~sck;
        ecnt <= ecnt + 1'b1;
        if (leading != cpha_q)
          rx <= lsb_q ? {miso, rx[DATA_W-1:1]} : {rx[DATA_W-2:0], miso};
        if ((leading && cpha_q) || (!leading && !cpha_q && !last_edge)) begin
          mosi <= first_bit(tx, lsb_q);
          tx   <= shift_word(tx, lsb_q);
        end
      end

      if (state == TRAIL && tick) begin
        done     <= 1'b1;
        data_out <= rx;
        if (!hold_q) ss_n <= '1;
      end
    end
  end
endmodule
